ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Two-requester arbiter and sequencer for the single-port 512×32 RAM behind MAR/MDR. Port A is the CPU memory path: MAR address, MDR write data, ReadRAM/WriteRAM intent. Port B is the program loader/debug port that preloads and inspects memory while the CPU is stalled or running. The block serialises accesses, drives the RAM's read/write/address/data pins, and returns read data and a completion pulse to the winning requester.

## Interface
Parameters:
- ADDR_W, 9, RAM address width
- DATA_W, 32, RAM data width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- clr  in  1  synchronous, active-high reset
- a_req  in  1  port A request; held high until a_done is sampled
- a_we  in  1  port A: 1 = write, 0 = read; stable while a_req is high
- a_addr  in  ADDR_W  port A address
- a_wdata  in  DATA_W  port A write data
- a_done  out  1  port A one-cycle completion pulse
- a_rdata  out  DATA_W  port A read data
- a_stall  out  1  a_req & ~a_done; the control unit holds its T-state while this is high
- b_req, b_we, b_addr, b_wdata, b_done, b_rdata  same as port A, for port B (no stall output)
- ram_read  out  1  RAM read enable
- ram_write  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data; synchronous, valid the cycle after ram_read

## Operation
- FSM states: IDLE, ACCESS, CAPTURE. Registered fields: owner (A/B), op_we, op_addr, op_wdata, rr_ptr (next preferred port), a_rdata_q, b_rdata_q.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one req: that port wins.
  - Both req: the port named by rr_ptr wins.
  - On a win: latch owner, we, addr, wdata; go to ACCESS.
- ACCESS:
  - ram_addr = op_addr, ram_wdata = op_wdata, ram_write = op_we, ram_read = ~op_we.
  - Write: owner's done = 1 this cycle; next state IDLE.
  - Read: next state CAPTURE.
- CAPTURE:
  - Owner's done = 1.
  - Owner's rdata = ram_rdata, combinational pass-through this cycle.
  - On the clock edge, ram_rdata loads into the owner's rdata_q; next state IDLE.
- Outside CAPTURE, x_rdata = x_rdata_q, which holds its last read value indefinitely.
- rr_ptr moves to the non-owner when a transaction completes (done cycle). This is strict alternation under contention.
- ram_read/ram_write are 0 in IDLE and CAPTURE. ram_addr/ram_wdata hold op_addr/op_wdata in all states.
- A requester drops req on the edge at which it samples done. A req still high in the following IDLE cycle starts a new transaction.
- Requests arriving while the FSM is busy wait; they are not lost.

## Timing
- Reset (clr high at an edge):
  - State → IDLE, rr_ptr → A.
  - op_*, a_rdata_q, b_rdata_q → 0.
  - Outputs: done=0, stall follows req, ram_read=ram_write=0, ram_addr=0, ram_wdata=0, rdata=0.
- ram_read and ram_write are gated with ~clr. Reset in mid-ACCESS therefore issues no RAM write that cycle. The aborted transaction gets no done pulse and must be re-requested.
- Write latency: req seen in IDLE at edge k, ACCESS in cycle k+1 with done. 2 cycles per write.
- Read latency: ACCESS in cycle k+1, CAPTURE with done and data in cycle k+2. 3 cycles per read.
- Back-to-back throughput with req held: one write per 2 cycles, one read per 3 cycles. IDLE always separates transactions.
- Only one done is ever high in a cycle. a_done and b_done are never both high.
- Worst-case wait for a requester under continuous contention is one foreign transaction (≤3 cycles) plus its own.
- Changing x_we/x_addr/x_wdata while the request is pending is illegal, but has no effect once the request is latched.

## Test plan
- Reset: drive random inputs with clr=1 for 3 cycles → all outputs 0 except a_stall=a_req; no ram_write pulse.
- Single write then read on A: write addr 0x05 data 0xDEADBEEF → a_done in cycle 2, ram_write high 1 cycle with addr 0x05. Then read 0x05 → a_done in cycle 3 with a_rdata=0xDEADBEEF, held afterwards.
- Simultaneous requests after reset: A read 0x10, B write 0x10=0x12345678 on the same cycle → A served first (reads old value 0). B completes on the next transaction; a re-read by A returns 0x12345678.
- Contention fairness: A and B both hold req for 20 cycles of writes → grants strictly alternate A,B,A,B. No done overlap; each port gets a transaction every 4 cycles.
- Reset mid-operation: B write 0x1FF=0xFFFFFFFF with clr asserted during ACCESS → no ram_write, no b_done. Memory at 0x1FF is unchanged when read back.
- Wrap/boundary: B reads address 0x1FF and A reads 0x000 in succession → correct ram_addr on each. b_rdata keeps its value while A's read updates only a_rdata.

Source files
------------

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-port synchronous RAM.
// Latency: write done 1 cycle after grant, read done+data 2 cycles after grant.
// Backpressure: requesters hold req until done; IDLE separates every transaction.
module ram_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_done,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_stall,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_done,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

    state_t            state;
    logic              owner;   // 0 = port A, 1 = port B
    logic              op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_wdata;
    logic              rr_ptr;  // port preferred on the next tie
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    logic grant_b;
    logic done_now;
    logic capture;

    assign grant_b = b_req & (~a_req | rr_ptr);

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            owner     <= 1'b0;
            op_we     <= 1'b0;
            op_addr   <= '0;
            op_wdata  <= '0;
            rr_ptr    <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (a_req | b_req) begin
                        owner    <= grant_b;
                        op_we    <= grant_b ? b_we    : a_we;
                        op_addr  <= grant_b ? b_addr  : a_addr;
                        op_wdata <= grant_b ? b_wdata : a_wdata;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (op_we) begin
                        rr_ptr <= ~owner;
                        state  <= IDLE;
                    end else begin
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (owner) b_rdata_q <= ram_rdata;
                    else       a_rdata_q <= ram_rdata;
                    rr_ptr <= ~owner;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Everything that commits or signals completion is gated by clr so a
    // reset landing mid-transaction leaves no trace in RAM or at the ports.
    assign done_now  = ~clr & (((state == ACCESS) & op_we) | (state == CAPTURE));
    assign capture   = ~clr & (state == CAPTURE);
    assign a_done    = done_now & ~owner;
    assign b_done    = done_now & owner;
    assign a_stall   = a_req & ~a_done;
    assign a_rdata   = (capture & ~owner) ? ram_rdata : a_rdata_q;
    assign b_rdata   = (capture & owner)  ? ram_rdata : b_rdata_q;
    assign ram_read  = ~clr & (state == ACCESS) & ~op_we;
    assign ram_write = ~clr & (state == ACCESS) & op_we;
    assign ram_addr  = op_addr;
    assign ram_wdata = op_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM model, transaction log, and a reference memory replay.
module tb_ram_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    logic          a_done, b_done, a_stall, ram_read, ram_write;
    logic [DW-1:0] a_rdata, b_rdata, ram_wdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_rdata = '0;
    logic [DW-1:0] mem [0:511] = '{default: '0};

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .clr(clr),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_done(a_done), .a_rdata(a_rdata), .a_stall(a_stall),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_done(b_done), .b_rdata(b_rdata),
        .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_wdata;
        if (ram_read)  ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        bit            p;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            cyc;
    } ent_t;

    ent_t          log_q[$];
    int            write_cnt = 0;
    int            overlap_cnt = 0;
    logic [AW-1:0] last_waddr = '0, last_raddr = '0;
    logic [DW-1:0] last_wdata = '0;

    always @(negedge clk) begin
        ent_t e;
        if (ram_write) begin
            write_cnt++;
            last_waddr = ram_addr;
            last_wdata = ram_wdata;
        end
        if (ram_read) last_raddr = ram_addr;
        if (a_done && b_done) overlap_cnt++;
        if (a_done) begin
            e.p = 1'b0; e.we = a_we; e.addr = a_addr; e.wdata = a_wdata;
            e.rdata = a_rdata; e.cyc = cyc;
            log_q.push_back(e);
        end
        if (b_done) begin
            e.p = 1'b1; e.we = b_we; e.addr = b_addr; e.wdata = b_wdata;
            e.rdata = b_rdata; e.cyc = cyc;
            log_q.push_back(e);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_port(input bit p, input bit req, input bit we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] d);
        if (p) begin
            b_req = req; b_we = we; b_addr = addr; b_wdata = d;
        end else begin
            a_req = req; a_we = we; a_addr = addr; a_wdata = d;
        end
    endtask

    task automatic do_reset(input int n);
        clr = 1'b1;
        tick(n);
        clr = 1'b0;
    endtask

    // Latency counts the cycle req is raised as cycle 1; 99 means no done seen.
    task automatic do_txn(input bit p, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd);
        bit got = 1'b0;
        set_port(p, 1'b1, we, addr, d);
        lat = 0;
        rd = '0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (p ? b_done : a_done) begin
                got = 1'b1;
                rd = p ? b_rdata : a_rdata;
            end
        end
        if (!got) lat = 99;
        @(posedge clk);
        #1;
        set_port(p, 1'b0, we, addr, d);
    endtask

    task automatic run_port(input bit p, input int n, input bit all_write,
                            input int max_gap, output int max_lat);
        int            lat, g, a;
        logic [DW-1:0] rd;
        logic [AW-1:0] ad;
        max_lat = 0;
        for (int i = 0; i < n; i++) begin
            g = $urandom_range(0, max_gap);
            if (g > 0) tick(g);
            a = $urandom_range(0, 15);
            ad = (a < 8) ? AW'(a) : AW'(a + 496);
            do_txn(p, all_write ? 1'b1 : 1'($urandom_range(0, 1)), ad, $urandom, lat, rd);
            if (lat > max_lat) max_lat = lat;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            set_port(0, 1'($urandom), 1'($urandom), AW'($urandom), $urandom);
            set_port(1, 1'($urandom), 1'($urandom), AW'($urandom), $urandom);
            @(posedge clk);
            #1;
            set_port(0, 1'($urandom), 1'($urandom), AW'($urandom), $urandom);
            set_port(1, 1'($urandom), 1'($urandom), AW'($urandom), $urandom);
            @(negedge clk);
            n_cmp++;
            if ({a_done, b_done, ram_read, ram_write} !== 4'b0) begin
                n_bad++;
                $display("FAIL reset_ctrl: got %b want 0000", {a_done, b_done, ram_read, ram_write});
            end
            n_cmp++;
            if (a_stall !== a_req) begin
                n_bad++;
                $display("FAIL reset_stall: got %b want %b", a_stall, a_req);
            end
            n_cmp++;
            if ({ram_addr, ram_wdata, a_rdata, b_rdata} !== '0) begin
                n_bad++;
                $display("FAIL reset_data: addr %h wdata %h a_rdata %h b_rdata %h want all 0",
                         ram_addr, ram_wdata, a_rdata, b_rdata);
            end
        end
        @(posedge clk);
        #1;
        set_port(0, 0, 0, '0, '0);
        set_port(1, 0, 0, '0, '0);
        clr = 1'b0;
        n_cmp++;
        if (write_cnt !== 0) begin
            n_bad++;
            $display("FAIL reset_no_write: got %0d writes want 0", write_cnt);
        end
    endtask

    task automatic test_single_write_read();
        int            lat, w0;
        logic [DW-1:0] rd;
        w0 = write_cnt;
        do_txn(0, 1'b1, 9'h005, 32'hDEADBEEF, lat, rd);
        n_cmp++;
        if (lat !== 2) begin
            n_bad++;
            $display("FAIL write_latency: got %0d want 2", lat);
        end
        n_cmp++;
        if (write_cnt - w0 !== 1 || last_waddr !== 9'h005 || last_wdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL write_pulse: got %0d pulses addr %h data %h want 1 005 deadbeef",
                     write_cnt - w0, last_waddr, last_wdata);
        end
        do_txn(0, 1'b0, 9'h005, '0, lat, rd);
        n_cmp++;
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL read_latency: got %0d want 3", lat);
        end
        n_cmp++;
        if (rd !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL read_data: got %h want deadbeef", rd);
        end
        tick(3);
        n_cmp++;
        if (a_rdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL read_hold: got %h want deadbeef", a_rdata);
        end
    endtask

    task automatic test_simultaneous();
        int            la, lb;
        logic [DW-1:0] ra, rb;
        do_reset(1);
        fork
            do_txn(0, 1'b0, 9'h010, '0, la, ra);
            do_txn(1, 1'b1, 9'h010, 32'h12345678, lb, rb);
        join
        n_cmp++;
        if (la !== 3 || ra !== 32'h0) begin
            n_bad++;
            $display("FAIL simul_a_first: got lat %0d data %h want 3 00000000", la, ra);
        end
        n_cmp++;
        if (lb !== 5) begin
            n_bad++;
            $display("FAIL simul_b_second: got lat %0d want 5", lb);
        end
        do_txn(0, 1'b0, 9'h010, '0, la, ra);
        n_cmp++;
        if (ra !== 32'h12345678) begin
            n_bad++;
            $display("FAIL simul_reread: got %h want 12345678", ra);
        end
    endtask

    task automatic test_fairness();
        int n0, ma, mb, ov0;
        do_reset(1);
        n0 = log_q.size();
        ov0 = overlap_cnt;
        fork
            run_port(0, 5, 1'b1, 0, ma);
            run_port(1, 5, 1'b1, 0, mb);
        join
        n_cmp++;
        if (log_q.size() - n0 !== 10) begin
            n_bad++;
            $display("FAIL fair_count: got %0d completions want 10", log_q.size() - n0);
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_cmp++;
                if (log_q[n0+i].p !== 1'(i % 2)) begin
                    n_bad++;
                    $display("FAIL fair_order[%0d]: got port %0d want %0d", i, log_q[n0+i].p, i % 2);
                end
                if (i >= 2) begin
                    n_cmp++;
                    if (log_q[n0+i].cyc - log_q[n0+i-2].cyc !== 4) begin
                        n_bad++;
                        $display("FAIL fair_period[%0d]: got %0d cycles want 4", i,
                                 log_q[n0+i].cyc - log_q[n0+i-2].cyc);
                    end
                end
            end
        end
        n_cmp++;
        if (ma !== 4 || mb !== 4) begin
            n_bad++;
            $display("FAIL fair_wait: got max lat A %0d B %0d want 4 4", ma, mb);
        end
        n_cmp++;
        if (overlap_cnt !== ov0) begin
            n_bad++;
            $display("FAIL fair_overlap: got %0d overlapping dones want 0", overlap_cnt - ov0);
        end
    endtask

    task automatic test_reset_mid();
        int            lat, w0;
        logic [DW-1:0] rd;
        do_txn(0, 1'b1, 9'h1FF, 32'h0BADF00D, lat, rd);
        w0 = write_cnt;
        set_port(1, 1'b1, 1'b1, 9'h1FF, 32'hFFFFFFFF);
        tick(1);
        clr = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ram_write !== 1'b0 || b_done !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_gate: got ram_write %b b_done %b want 0 0", ram_write, b_done);
        end
        tick(1);
        clr = 1'b0;
        set_port(1, 1'b0, 1'b0, '0, '0);
        n_cmp++;
        if (write_cnt !== w0) begin
            n_bad++;
            $display("FAIL midreset_writes: got %0d extra writes want 0", write_cnt - w0);
        end
        do_txn(1, 1'b0, 9'h1FF, '0, lat, rd);
        n_cmp++;
        if (rd !== 32'h0BADF00D) begin
            n_bad++;
            $display("FAIL midreset_mem: got %h want 0badf00d", rd);
        end
    endtask

    task automatic test_wrap();
        int            lat;
        logic [DW-1:0] rd;
        do_txn(0, 1'b1, 9'h000, 32'hA5A55A5A, lat, rd);
        do_txn(1, 1'b0, 9'h1FF, '0, lat, rd);
        n_cmp++;
        if (rd !== 32'h0BADF00D || last_raddr !== 9'h1FF) begin
            n_bad++;
            $display("FAIL wrap_b_read: got data %h addr %h want 0badf00d 1ff", rd, last_raddr);
        end
        do_txn(0, 1'b0, 9'h000, '0, lat, rd);
        n_cmp++;
        if (rd !== 32'hA5A55A5A || last_raddr !== 9'h000) begin
            n_bad++;
            $display("FAIL wrap_a_read: got data %h addr %h want a5a55a5a 000", rd, last_raddr);
        end
        tick(2);
        n_cmp++;
        if (b_rdata !== 32'h0BADF00D || a_rdata !== 32'hA5A55A5A) begin
            n_bad++;
            $display("FAIL wrap_hold: got b %h a %h want 0badf00d a5a55a5a", b_rdata, a_rdata);
        end
    endtask

    task automatic test_random();
        int            ma, mb, ov0;
        logic [DW-1:0] ref_m [0:511];
        logic [DW-1:0] last_a;
        bit            have_a = 1'b0;
        ov0 = overlap_cnt;
        fork
            run_port(0, 40, 1'b0, 3, ma);
            run_port(1, 40, 1'b0, 3, mb);
        join
        n_cmp++;
        if (ma > 6 || mb > 6) begin
            n_bad++;
            $display("FAIL rand_wait: got max lat A %0d B %0d want <= 6", ma, mb);
        end
        n_cmp++;
        if (overlap_cnt !== ov0) begin
            n_bad++;
            $display("FAIL rand_overlap: got %0d overlapping dones want 0", overlap_cnt - ov0);
        end
        // Replay every completed transaction, in completion order, against a flat memory.
        for (int i = 0; i < 512; i++) ref_m[i] = '0;
        last_a = '0;
        foreach (log_q[i]) begin
            if (log_q[i].we) begin
                ref_m[log_q[i].addr] = log_q[i].wdata;
            end else begin
                n_cmp++;
                if (log_q[i].rdata !== ref_m[log_q[i].addr]) begin
                    n_bad++;
                    $display("FAIL rand_read[%0d]: port %0d addr %h got %h want %h", i,
                             log_q[i].p, log_q[i].addr, log_q[i].rdata, ref_m[log_q[i].addr]);
                end
                if (!log_q[i].p) begin
                    last_a = ref_m[log_q[i].addr];
                    have_a = 1'b1;
                end
            end
        end
        if (have_a) begin
            n_cmp++;
            if (a_rdata !== last_a) begin
                n_bad++;
                $display("FAIL rand_a_hold: got %h want %h", a_rdata, last_a);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_write_read();
        test_simultaneous();
        test_fairness();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
